weight_mem_arbiter: RTL and testbench
=====================================

WEIGHT_MEM_ARBITER -- requirements
Module: weight_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNKNOWNS, default 2, giving the number of beats per burst (one weight word per unknown).
REQ-002 SHALL have parameter ADDR_W, default 4, giving the weight RAM address width.
REQ-003 SHALL have parameter DATA_W, default 32, giving the weight word width.
REQ-004 SHALL have port clk  in  1, the system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1, an asynchronous, active-high reset.
REQ-006 SHALL have port freeze  in  1; when 1, no new grant is issued.
REQ-007 SHALL have port req  in  3, burst requests: bit0 ROM loader, bit1 trainer writeback, bit2 host readout.
REQ-008 SHALL have port we  in  3, per-requester write (1) or read (0) selection.
REQ-009 SHALL have port base_addr  in  3*ADDR_W, per-requester burst base address; requester i occupies slice i.
REQ-010 SHALL have port wdata  in  3*DATA_W, per-requester write data, supplied per beat.
REQ-011 SHALL have port mem_rdata  in  DATA_W, the RAM read data, valid 1 cycle after a read access.
REQ-012 SHALL have port gnt  out  3, the one-hot grant, held for the whole burst.
REQ-013 SHALL have port beat_idx  out  clog2(NUM_UNKNOWNS)+1, the current beat number, 0..NUM_UNKNOWNS-1.
REQ-014 SHALL have port burst_done  out  1, a pulse on the last beat of a burst.
REQ-015 SHALL have ports mem_en, mem_we  out  1 each, the RAM strobes.
REQ-016 SHALL have ports mem_addr  out  ADDR_W and mem_wdata  out  DATA_W, the RAM address and write data.
REQ-017 SHALL have port rd_valid  out  3, a one-hot read-data qualifier per requester.
REQ-018 SHALL have port rd_data  out  DATA_W, the returned read word.

Function
REQ-019 SHALL implement FSM states IDLE, BURST, GAP; transitions IDLE->BURST on a grant, BURST->GAP after the last beat, GAP->IDLE unconditionally.
REQ-020 SHALL arbitrate only in IDLE and only when freeze=0 and req!=0, registering gnt, the granted we, and the granted base_addr at that edge.
REQ-021 SHALL give ROM (bit0) fixed highest priority; trainer and host SHALL alternate round-robin via a 1-bit pointer, reset to favour the trainer and toggled after each trainer or host grant.
REQ-022 SHALL, in BURST, assert mem_en=1 for exactly NUM_UNKNOWNS consecutive cycles with beat_idx counting 0..NUM_UNKNOWNS-1.
REQ-023 SHALL drive mem_addr = (latched base + beat_idx) mod 2^ADDR_W, wrapping from 2^ADDR_W-1 to 0.
REQ-024 SHALL drive mem_we = latched we AND mem_en, and mem_wdata = wdata slice of the granted requester; mem_wdata is don't-care on reads.
REQ-025 SHALL assert burst_done on the beat with beat_idx=NUM_UNKNOWNS-1 only.
REQ-026 SHALL, for each read beat, assert rd_valid one-hot for the granted requester exactly 1 cycle later with rd_data=mem_rdata; the last read-beat response falls in GAP.
REQ-027 SHALL clear gnt in GAP; GAP is a 1-cycle turnaround with mem_en=0.
REQ-028 SHALL run a started burst to completion even if req drops, freeze rises, or a higher-priority request arrives.
REQ-029 SHALL NOT re-grant the same requester without an intervening GAP and IDLE cycle; minimum burst-to-burst spacing is NUM_UNKNOWNS+2 cycles.
REQ-030 SHALL keep all outputs 0 in IDLE.

Reset
REQ-031 SHALL, on rst=1 at any time, set the state to IDLE and gnt, beat_idx, burst_done, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data to 0, and the round-robin pointer to trainer.
REQ-032 SHALL drop any in-flight read response on reset mid-burst, with no rd_valid after reset release.

Verification
REQ-033 SHALL cover reset: rst pulse mid-BURST -> all outputs 0 the same cycle; first grant possible 1 cycle after release.
REQ-034 SHALL cover a ROM write burst: req=001, we=001, base0=4, NUM_UNKNOWNS=2, cycle0 -> gnt=001 in cycles 1-2, mem_addr 4,5, mem_we=1, burst_done in cycle 2, gnt=000 in cycle 3.
REQ-035 SHALL cover round-robin: req=110 held, both reads -> grants trainer, then host, then trainer; rd_valid=010 twice then 100 twice, each 1 cycle after the matching mem_en.
REQ-036 SHALL cover pre-emption: ROM req arrives mid trainer burst -> trainer burst completes unchanged; ROM is granted at the next IDLE even though host is pending.
REQ-037 SHALL cover wrap: base=15, ADDR_W=4 -> mem_addr 15 then 0.
REQ-038 SHALL cover freeze: freeze=1 with req=010 -> no grant for 10 cycles; freeze rising mid-burst -> burst finishes and no new grant follows.

Source files
------------

// File: rtl/weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// weight_mem_arbiter
//
// Purpose:
//    Arbitrates three burst requesters onto a single weight RAM port. Each
//    granted burst moves NUM_UNKNOWNS consecutive words (one per unknown),
//    starting at the requester's base address and wrapping modulo 2^ADDR_W.
//    The ROM loader (requester 0) has fixed highest priority. The trainer
//    writeback (requester 1) and host readout (requester 2) share the
//    remaining bandwidth through a 1-bit round-robin pointer. Every burst is
//    followed by a one-cycle GAP turnaround, and then by at least one IDLE
//    cycle before the next grant.
//
// Ports:
//    clk        - system clock; all state updates on its rising edge
//    rst        - asynchronous, active-high reset
//    freeze     - when 1, no new grant is issued (a running burst still ends)
//    req[2:0]   - burst requests: bit0 ROM, bit1 trainer, bit2 host
//    we[2:0]    - per-requester write (1) / read (0) selection
//    base_addr  - per-requester burst base address, requester i in slice i
//    wdata      - per-requester write data, supplied per beat, slice i
//    mem_rdata  - RAM read data, valid one cycle after a read access
//    gnt[2:0]   - one-hot grant, held for the whole burst
//    beat_idx   - current beat number within the burst
//    burst_done - pulse on the last beat of a burst
//    mem_en     - RAM enable, high for every beat of a burst
//    mem_we     - RAM write strobe
//    mem_addr   - RAM address
//    mem_wdata  - RAM write data
//    rd_valid   - one-hot read-data qualifier, one cycle after each read beat
//    rd_data    - returned read word
// -----------------------------------------------------------------------------
module weight_mem_arbiter #(
   parameter int NUM_UNKNOWNS = 2,
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          freeze,
   input  logic [2:0]                    req,
   input  logic [2:0]                    we,
   input  logic [3*ADDR_W-1:0]           base_addr,
   input  logic [3*DATA_W-1:0]           wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [2:0]                    gnt,
   output logic [$clog2(NUM_UNKNOWNS):0] beat_idx,
   output logic                          burst_done,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [2:0]                    rd_valid,
   output logic [DATA_W-1:0]             rd_data
);

   localparam int BEAT_W = $clog2(NUM_UNKNOWNS) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_UNKNOWNS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_t;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   state_t              state_reg,    state_next;
   logic [2:0]          gnt_reg,      gnt_next;
   logic                we_reg,       we_next;
   logic [ADDR_W-1:0]   base_reg,     base_next;
   logic [BEAT_W-1:0]   beat_reg,     beat_next;
   logic                rr_ptr_reg,   rr_ptr_next;   // 0 favours trainer, 1 favours host
   logic [2:0]          rd_valid_reg, rd_valid_next;

   // Candidate grant, evaluated every cycle but only taken in IDLE.
   logic [2:0]          grant_sel;
   logic [ADDR_W-1:0]   base_sel;
   logic                we_sel;
   logic [DATA_W-1:0]   wdata_sel;

   logic                in_burst;
   logic                last_beat;

   // --------------------------------------------------------------------------
   // Priority / round-robin selection
   // --------------------------------------------------------------------------
   always_comb begin
      grant_sel = 3'b000;
      if (req[0]) begin
         grant_sel = 3'b001;
      end else if (req[1] && req[2]) begin
         grant_sel = rr_ptr_reg ? 3'b100 : 3'b010;
      end else if (req[1]) begin
         grant_sel = 3'b010;
      end else if (req[2]) begin
         grant_sel = 3'b100;
      end
   end

   // --------------------------------------------------------------------------
   // One-hot AND-OR muxes: base/we follow the candidate grant (latched at the
   // grant edge), write data follows the registered grant (live per beat).
   // --------------------------------------------------------------------------
   logic [ADDR_W-1:0] base_masked  [3];
   logic [DATA_W-1:0] wdata_masked [3];

   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_req_mux
      assign base_masked[gi]  = grant_sel[gi] ? base_addr[gi*ADDR_W +: ADDR_W] : '0;
      assign wdata_masked[gi] = gnt_reg[gi]   ? wdata[gi*DATA_W +: DATA_W]     : '0;
   end

   assign base_sel  = base_masked[0]  | base_masked[1]  | base_masked[2];
   assign wdata_sel = wdata_masked[0] | wdata_masked[1] | wdata_masked[2];
   assign we_sel    = |(we & grant_sel);

   assign in_burst  = (state_reg == BURST);
   assign last_beat = (beat_reg == LAST_BEAT);

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         gnt_reg      <= 3'b000;
         we_reg       <= 1'b0;
         base_reg     <= '0;
         beat_reg     <= '0;
         rr_ptr_reg   <= 1'b0;
         rd_valid_reg <= 3'b000;
      end else begin
         state_reg    <= state_next;
         gnt_reg      <= gnt_next;
         we_reg       <= we_next;
         base_reg     <= base_next;
         beat_reg     <= beat_next;
         rr_ptr_reg   <= rr_ptr_next;
         rd_valid_reg <= rd_valid_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      we_next     = we_reg;
      base_next   = base_reg;
      beat_next   = beat_reg;
      rr_ptr_next = rr_ptr_reg;

      // A read beat this cycle means the RAM answers next cycle; the
      // qualifier is simply the grant delayed by one cycle.
      rd_valid_next = (in_burst && !we_reg) ? gnt_reg : 3'b000;

      case (state_reg)
         IDLE: begin
            if (!freeze && (req != 3'b000)) begin
               state_next = BURST;
               gnt_next   = grant_sel;
               we_next    = we_sel;
               base_next  = base_sel;
               beat_next  = '0;
               // Only trainer/host grants move the pointer; ROM grants leave it.
               if (!grant_sel[0]) begin
                  rr_ptr_next = ~rr_ptr_reg;
               end
            end
         end

         BURST: begin
            // Inputs are ignored here: a started burst always completes.
            if (last_beat) begin
               state_next = GAP;
               gnt_next   = 3'b000;
               beat_next  = '0;
            end else begin
               beat_next = beat_reg + 1'b1;
            end
         end

         GAP: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            gnt_next   = 3'b000;
            beat_next  = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs: everything beat-related is gated by BURST so IDLE and GAP
   // drive zeros.
   // --------------------------------------------------------------------------
   assign gnt        = gnt_reg;
   assign mem_en     = in_burst;
   assign mem_we     = in_burst & we_reg;
   assign beat_idx   = in_burst ? beat_reg : '0;
   assign burst_done = in_burst & last_beat;
   assign mem_addr   = in_burst ? (base_reg + ADDR_W'(beat_reg)) : '0;
   assign mem_wdata  = in_burst ? wdata_sel : '0;

   // rd_data passes the RAM output straight through in the response cycle,
   // so a reset (which clears rd_valid_reg) drops any in-flight word.
   assign rd_valid = rd_valid_reg;
   assign rd_data  = (rd_valid_reg != 3'b000) ? mem_rdata : '0;

endmodule

// File: tb/tb_weight_mem_arbiter.sv
module tb_weight_mem_arbiter;

   localparam int N  = 2;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int BW = $clog2(N) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              freeze = 1'b0;
   logic [2:0]        req = '0;
   logic [2:0]        we = '0;
   logic [3*AW-1:0]   base_addr = '0;
   logic [3*DW-1:0]   wdata = '0;
   logic [DW-1:0]     mem_rdata = '0;
   logic [2:0]        gnt;
   logic [BW-1:0]     beat_idx;
   logic              burst_done;
   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [2:0]        rd_valid;
   logic [DW-1:0]     rd_data;

   int checks = 0;
   int errors = 0;

   weight_mem_arbiter #(.NUM_UNKNOWNS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .req        (req),
      .we         (we),
      .base_addr  (base_addr),
      .wdata      (wdata),
      .mem_rdata  (mem_rdata),
      .gnt        (gnt),
      .beat_idx   (beat_idx),
      .burst_done (burst_done),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   // Read-only RAM image: word content is a fixed function of its address.
   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      return {a, 4'h0, ~a, 4'hA, a, 4'h3, ~a, 4'hC};
   endfunction

   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= ram_word(mem_addr);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: a burst is "who/we/base" plus a position counter
   // (-1 idle, 0..N-1 beats, N turnaround); reads are answered one cycle later.
   // ---------------------------------------------------------------------
   int           m_pos = -1;
   int           m_who = 0;
   logic         m_we = 1'b0;
   logic [AW-1:0] m_base = '0;
   logic         m_ptr = 1'b0;
   logic         resp_pend = 1'b0;
   int           resp_who = 0;
   logic [AW-1:0] resp_addr = '0;

   task automatic step(input logic r, input logic f, input logic [2:0] rq, input logic [2:0] w,
                       input logic [3*AW-1:0] b, input logic [3*DW-1:0] d);
      logic [2:0]    e_gnt, e_rv;
      logic          e_en, e_we, e_done, in_b, idle;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_beat;
      logic [DW-1:0] e_wd, e_rd;
      int            who;
      @(negedge clk);
      rst = r; freeze = f; req = rq; we = w; base_addr = b; wdata = d;
      #2;
      e_gnt = '0; e_rv = '0; e_en = 0; e_we = 0; e_done = 0; e_addr = '0;
      e_beat = '0; e_wd = '0; e_rd = '0;
      in_b = !r && (m_pos >= 0) && (m_pos < N);
      idle = r || (m_pos == -1);
      if (in_b) begin
         e_gnt  = 3'(1 << m_who);
         e_en   = 1'b1;
         e_we   = m_we;
         e_addr = m_base + AW'(m_pos);
         e_beat = BW'(m_pos);
         e_done = (m_pos == N - 1);
         e_wd   = d[m_who*DW +: DW];
      end
      if (!r && resp_pend) begin
         e_rv = 3'(1 << resp_who);
         e_rd = ram_word(resp_addr);
      end
      chk("gnt", gnt, e_gnt);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("beat_idx", beat_idx, e_beat);
      chk("burst_done", burst_done, e_done);
      chk("rd_valid", rd_valid, e_rv);
      if ((in_b && m_we) || idle) chk("mem_wdata", mem_wdata, e_wd);
      if ((e_rv != 0) || idle) chk("rd_data", rd_data, e_rd);
      // advance model across the coming rising edge
      if (r) begin
         m_pos = -1; m_ptr = 1'b0; resp_pend = 1'b0;
      end else begin
         resp_pend = in_b && !m_we;
         resp_who  = m_who;
         resp_addr = e_addr;
         if (m_pos == -1) begin
            if (!f && rq != 3'b000) begin
               if (rq[0])               who = 0;
               else if (rq[1] && rq[2]) who = m_ptr ? 2 : 1;
               else if (rq[1])          who = 1;
               else                     who = 2;
               if (who != 0) m_ptr = ~m_ptr;
               m_who  = who;
               m_we   = w[who];
               m_base = b[who*AW +: AW];
               m_pos  = 0;
               $display("burst: requester %0d we=%0b base=%0d", who, m_we, m_base);
            end
         end else if (m_pos < N) begin
            m_pos++;
         end else begin
            m_pos = -1;
         end
      end
   endtask

   // ---------------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------------
   typedef struct {
      logic          r;
      logic [2:0]    rq;
      logic [2:0]    w;
      logic [2:0]    e_gnt;
      logic          e_en;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic          e_done;
      logic [2:0]    e_rv;
   } vec_t;

   function automatic vec_t mk(logic r, logic [2:0] rq, logic [2:0] w, logic [2:0] g,
                               logic en, logic mw, logic [AW-1:0] a, logic dn, logic [2:0] rv);
      vec_t v;
      v.r = r; v.rq = rq; v.w = w; v.e_gnt = g; v.e_en = en; v.e_we = mw;
      v.e_addr = a; v.e_done = dn; v.e_rv = rv;
      return v;
   endfunction

   vec_t tbl [18];
   logic [3*AW-1:0] tbl_base;
   logic [3*DW-1:0] tbl_wd;

   initial begin
      tbl_base = {4'd7, 4'd15, 4'd4};
      tbl_wd   = {32'h2222_2222, 32'h1111_1111, 32'hCAFE_0001};
      // ROM write burst at base 4
      tbl[0]  = mk(1, 3'b000, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b000);
      tbl[1]  = mk(0, 3'b001, 3'b001, 3'b000, 0, 0, 4'd0,  0, 3'b000);
      tbl[2]  = mk(0, 3'b000, 3'b000, 3'b001, 1, 1, 4'd4,  0, 3'b000);
      tbl[3]  = mk(0, 3'b000, 3'b000, 3'b001, 1, 1, 4'd5,  1, 3'b000);
      tbl[4]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b000);
      // trainer/host round-robin reads; trainer base 15 wraps
      tbl[5]  = mk(0, 3'b110, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b000);
      tbl[6]  = mk(0, 3'b110, 3'b000, 3'b010, 1, 0, 4'd15, 0, 3'b000);
      tbl[7]  = mk(0, 3'b110, 3'b000, 3'b010, 1, 0, 4'd0,  1, 3'b010);
      tbl[8]  = mk(0, 3'b110, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b010);
      tbl[9]  = mk(0, 3'b110, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b000);
      tbl[10] = mk(0, 3'b110, 3'b000, 3'b100, 1, 0, 4'd7,  0, 3'b000);
      tbl[11] = mk(0, 3'b110, 3'b000, 3'b100, 1, 0, 4'd8,  1, 3'b100);
      tbl[12] = mk(0, 3'b110, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b100);
      tbl[13] = mk(0, 3'b110, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b000);
      tbl[14] = mk(0, 3'b000, 3'b000, 3'b010, 1, 0, 4'd15, 0, 3'b000);
      tbl[15] = mk(0, 3'b000, 3'b000, 3'b010, 1, 0, 4'd0,  1, 3'b010);
      tbl[16] = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b010);
      tbl[17] = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 4'd0,  0, 3'b000);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, 1'b0, tbl[i].rq, tbl[i].w, tbl_base, tbl_wd);
         chk($sformatf("tbl%0d.gnt", i),      gnt,        tbl[i].e_gnt);
         chk($sformatf("tbl%0d.mem_en", i),   mem_en,     tbl[i].e_en);
         chk($sformatf("tbl%0d.mem_we", i),   mem_we,     tbl[i].e_we);
         chk($sformatf("tbl%0d.mem_addr", i), mem_addr,   tbl[i].e_addr);
         chk($sformatf("tbl%0d.done", i),     burst_done, tbl[i].e_done);
         chk($sformatf("tbl%0d.rd_valid", i), rd_valid,   tbl[i].e_rv);
      end

      // Pre-emption: ROM arrives mid trainer burst, wins next IDLE over host
      step(0, 0, 3'b010, 3'b000, tbl_base, tbl_wd);
      step(0, 0, 3'b111, 3'b000, tbl_base, tbl_wd);
      chk("preempt.beat0.gnt", gnt, 3'b010);
      chk("preempt.beat0.addr", mem_addr, 4'd15);
      step(0, 0, 3'b111, 3'b000, tbl_base, tbl_wd);
      chk("preempt.beat1.gnt", gnt, 3'b010);
      chk("preempt.beat1.addr", mem_addr, 4'd0);
      step(0, 0, 3'b111, 3'b000, tbl_base, tbl_wd);
      chk("preempt.gap.gnt", gnt, 3'b000);
      step(0, 0, 3'b111, 3'b000, tbl_base, tbl_wd);
      chk("preempt.idle.gnt", gnt, 3'b000);
      step(0, 0, 3'b000, 3'b000, tbl_base, tbl_wd);
      chk("preempt.rom.gnt", gnt, 3'b001);
      chk("preempt.rom.addr", mem_addr, 4'd4);
      for (int i = 0; i < 3; i++) step(0, 0, 3'b000, 3'b000, tbl_base, tbl_wd);

      // Freeze: no grant for 10 cycles
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 3'b010, 3'b010, tbl_base, tbl_wd);
         chk($sformatf("freeze%0d.gnt", i), gnt, 3'b000);
         chk($sformatf("freeze%0d.mem_en", i), mem_en, 1'b0);
      end
      // Freeze rising mid-burst: burst finishes, nothing follows
      step(0, 0, 3'b010, 3'b010, tbl_base, tbl_wd);
      step(0, 1, 3'b010, 3'b010, tbl_base, tbl_wd);
      chk("frzburst.beat0.gnt", gnt, 3'b010);
      chk("frzburst.beat0.we", mem_we, 1'b1);
      step(0, 1, 3'b010, 3'b010, tbl_base, tbl_wd);
      chk("frzburst.beat1.done", burst_done, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 3'b010, 3'b010, tbl_base, tbl_wd);
         chk($sformatf("frzafter%0d.gnt", i), gnt, 3'b000);
         chk($sformatf("frzafter%0d.mem_en", i), mem_en, 1'b0);
      end

      // Reset mid read burst: in-flight response dropped, grant 1 cycle after release
      step(0, 0, 3'b100, 3'b000, tbl_base, tbl_wd);
      step(0, 0, 3'b000, 3'b000, tbl_base, tbl_wd);
      chk("rstmid.beat0.gnt", gnt, 3'b100);
      step(1, 0, 3'b000, 3'b000, tbl_base, tbl_wd);
      chk("rstmid.gnt", gnt, 3'b000);
      chk("rstmid.mem_en", mem_en, 1'b0);
      chk("rstmid.rd_valid", rd_valid, 3'b000);
      step(0, 0, 3'b001, 3'b001, tbl_base, tbl_wd);
      chk("rstrel.rd_valid", rd_valid, 3'b000);
      chk("rstrel.gnt", gnt, 3'b000);
      step(0, 0, 3'b000, 3'b000, tbl_base, tbl_wd);
      chk("rstrel.first_gnt", gnt, 3'b001);
      for (int i = 0; i < 3; i++) step(0, 0, 3'b000, 3'b000, tbl_base, tbl_wd);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         logic          r, f;
         logic [2:0]    rq, w;
         logic [3*AW-1:0] b;
         logic [3*DW-1:0] d;
         r  = ($urandom_range(0, 199) == 0);
         f  = ($urandom_range(0, 9) == 0);
         rq = 3'($urandom_range(0, 7));
         w  = 3'($urandom_range(0, 7));
         b  = 12'($urandom);
         d  = {$urandom, $urandom, $urandom};
         step(r, f, rq, w, b, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
